// File: rtl/uart_msg_loader_if.sv
// uart_msg_loader_if: serial line in, assembled word plus valid/frame_err/timeout_err/busy out
interface uart_msg_loader_if #(parameter int WIDTH = 32);
  logic uart_rxd;
  logic [WIDTH-1:0] msg_out;
  logic msg_valid;
  logic frame_err;
  logic timeout_err;
  logic busy;
  modport master(input uart_rxd, output msg_out, msg_valid, frame_err, timeout_err, busy);
  modport slave(output uart_rxd, input msg_out, msg_valid, frame_err, timeout_err, busy);
endinterface

// File: rtl/uart_msg_loader.sv
// uart_msg_loader: 8N1 UART receiver packing bytes MSB-first into WIDTH-bit words (clk, reset, bus: uart_rxd in; msg_out/msg_valid/frame_err/timeout_err/busy out)
module uart_msg_loader #(
  parameter int WIDTH = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input logic clk,
  input logic reset,
  uart_msg_loader_if.master bus
);
  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic rx_m, rx;
  logic [1:0] state;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic [WIDTH-1:0] word;
  logic [3:0] byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic tick, accept, bad, full, tmo;
  always_comb begin
    tick = baud == '0;
    accept = state == STOP && tick && rx;
    bad = state == STOP && tick && !rx;
    full = byte_cnt == 4'(NB);
    tmo = state == IDLE && byte_cnt != 4'd0 && idle_cnt == TW'(TIMEOUT_CLKS);
  end
  assign bus.busy = state != IDLE || byte_cnt != 4'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx <= 1'b1;
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      sh <= '0;
      word <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      bus.msg_out <= '0;
      bus.msg_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      rx_m <= bus.uart_rxd;
      rx <= rx_m;
      case (state)
        IDLE: if (!rx) begin
          state <= START;
          baud <= CW'(CLKS_PER_BIT / 2 - 1);
        end
        START: if (tick) begin
          state <= rx ? IDLE : DATA;
          baud <= CW'(CLKS_PER_BIT - 1);
          bit_idx <= '0;
        end else baud <= baud - CW'(1);
        DATA: if (tick) begin
          sh <= {rx, sh[7:1]};
          baud <= CW'(CLKS_PER_BIT - 1);
          bit_idx <= bit_idx + 3'd1;
          state <= bit_idx == 3'd7 ? STOP : DATA;
        end else baud <= baud - CW'(1);
        default: if (tick) state <= IDLE;
          else baud <= baud - CW'(1);
      endcase
      if (accept) word <= WIDTH'({word, sh});
      byte_cnt <= accept ? byte_cnt + 4'd1 : (bad || full || tmo) ? 4'd0 : byte_cnt;
      idle_cnt <= (state == IDLE && rx && byte_cnt != 4'd0 && !tmo) ? idle_cnt + TW'(1) : '0;
      if (full) bus.msg_out <= word;
      bus.msg_valid <= full;
      bus.frame_err <= bad;
      bus.timeout_err <= tmo;
    end
  end
endmodule

// File: tb/tb_uart_msg_loader.sv
// tb_uart_msg_loader: directed and random frames checked against a byte-queue reference model
module tb_uart_msg_loader;
  localparam int CPB = 16;
  localparam int TO = 2000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_msg_loader_if #(.WIDTH(32)) bus();
  uart_msg_loader #(.WIDTH(32), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int n_valid = 0, n_ferr = 0, n_tmo = 0, viol = 0;
  int e_ferr = 0, e_tmo = 0;
  bit saw_aabb = 1'b0;
  logic [31:0] prev = '0;
  logic [31:0] got[$];
  logic [31:0] expw[$];
  logic [7:0] pend[$];
  always @(posedge clk) begin
    #1;
    if (!reset && bus.msg_out !== prev && bus.msg_valid !== 1'b1) viol++;
    prev = bus.msg_out;
    if (bus.msg_valid === 1'b1) begin
      n_valid++;
      got.push_back(bus.msg_out);
    end
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.timeout_err === 1'b1) n_tmo++;
    if (bus.msg_out === 32'h0000AABB) saw_aabb = 1'b1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit stop, input int gap);
    bus.uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (gap) @(negedge clk);
    if (!stop) begin
      e_ferr++;
      pend.delete();
    end else begin
      pend.push_back(b);
      if (pend.size() == 4) begin
        expw.push_back({pend[0], pend[1], pend[2], pend[3]});
        pend.delete();
      end else if (gap > TO) begin
        e_tmo++;
        pend.delete();
      end
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_nvalid"}, 64'(n_valid), 64'(expw.size()));
    for (int i = 0; i < expw.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), i < got.size() ? 64'(got[i]) : 64'hx, 64'(expw[i]));
    chk({tag, "_ferr"}, 64'(n_ferr), 64'(e_ferr));
    chk({tag, "_tmo"}, 64'(n_tmo), 64'(e_tmo));
    chk({tag, "_hold"}, 64'(viol), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    bus.uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_msg_out", 64'(bus.msg_out), 64'd0);
    chk("rst_valid", 64'(bus.msg_valid), 64'd0);
    chk("rst_ferr", 64'(bus.frame_err), 64'd0);
    chk("rst_tmo", 64'(bus.timeout_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h00, 1, 0);
    send(8'h00, 1, 0);
    send(8'h00, 1, 0);
    send(8'h02, 1, 40);
    check_all("word02");
    chk("word02_out", 64'(bus.msg_out), 64'h2);
    send(8'h12, 0, 24);
    chk("ferr_hold", 64'(bus.msg_out), 64'h2);
    send(8'hDE, 1, 0);
    send(8'hAD, 1, 0);
    send(8'hBE, 1, 0);
    send(8'hEF, 1, 40);
    check_all("deadbeef");
    chk("deadbeef_out", 64'(bus.msg_out), 64'hDEADBEEF);
    bus.uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_idle", 64'(bus.busy), 64'd0);
    check_all("glitch");
    send(8'hAA, 1, 0);
    send(8'hBB, 1, 2001);
    chk("timeout_busy", 64'(bus.busy), 64'd0);
    send(8'h01, 1, 0);
    send(8'h02, 1, 0);
    send(8'h03, 1, 0);
    send(8'h04, 1, 40);
    check_all("timeout");
    chk("timeout_out", 64'(bus.msg_out), 64'h01020304);
    chk("no_aabb", 64'(saw_aabb), 64'd0);
    send(8'h55, 1, 0);
    bus.uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.uart_rxd = i[0];
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.uart_rxd = 1'b1;
    pend.delete();
    repeat (30) @(negedge clk);
    chk("midrst_out", 64'(bus.msg_out), 64'd0);
    check_all("midrst");
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    send(8'h33, 1, 0);
    send(8'h44, 1, 40);
    check_all("after_rst");
    chk("after_rst_out", 64'(bus.msg_out), 64'h11223344);
    for (int i = 1; i <= 8; i++) send(8'(i), 1, i == 8 ? 40 : 0);
    check_all("b2b");
    chk("b2b_out", 64'(bus.msg_out), 64'h05060708);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit stop;
      int gap;
      b = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      gap = $urandom_range(0, 9) == 0 ? $urandom_range(2100, 2300) : $urandom_range(0, 30);
      if (!stop && gap < 20) gap = 20;
      send(b, stop, gap);
    end
    repeat (2200) @(negedge clk);
    if (pend.size() != 0) begin
      e_tmo++;
      pend.delete();
    end
    check_all("random");
    if (expw.size() != 0) chk("random_out", 64'(bus.msg_out), 64'(expw[expw.size()-1]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
